// File: rtl/led_matrix_scan.sv
// Row-scanning red/green dot-matrix driver: shows a captured water level as a bottom-up bar,
// with blink, beeper and acknowledge-to-mute while the level is at alarm.
module led_matrix_scan #(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned COLS        = 8,
  parameter int unsigned LVL_W       = 3,
  parameter int unsigned WARN_LEVEL  = 4,
  parameter int unsigned ALARM_LEVEL = 7,
  parameter int unsigned SCAN_DIV    = 4,
  parameter int unsigned BLINK_FR    = 16,
  parameter int unsigned BEEP_DIV    = 2,
  parameter bit          ROW_ACT_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] state,
  input  logic             btn_ack,
  output logic [ROWS-1:0]  row,
  output logic [COLS-1:0]  red_led,
  output logic [COLS-1:0]  green_led,
  output logic             beeper,
  output logic             alarm
);

  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRAME_W = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  localparam int unsigned BEEP_W  = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam int unsigned FILL_W  = LVL_W + $clog2(ROWS + 1);

  localparam logic [ROWS-1:0]   ROW_IDLE  = {ROWS{ROW_ACT_LOW}};
  localparam logic [LVL_W-1:0]  LVL_WARN  = LVL_W'(WARN_LEVEL);
  localparam logic [LVL_W-1:0]  LVL_ALARM = LVL_W'(ALARM_LEVEL);

  typedef enum logic [1:0] {
    S_NORMAL,
    S_ALARM,
    S_MUTED
  } alarm_state_t;

  alarm_state_t       alarm_st;
  alarm_state_t       alarm_nxt;

  logic [SLOT_W-1:0]  slot;
  logic [ROW_W-1:0]   row_idx;
  logic [LVL_W-1:0]   lvl_q;
  logic [1:0]         ack_sync;
  logic               ack_prev;
  logic [FRAME_W-1:0] frame_cnt;
  logic               dark;
  logic [BEEP_W-1:0]  beep_cnt;

  logic               slot_last;
  logic               row_last;
  logic               frame_wrap;
  logic               ack_pulse;
  logic               lvl_alarm;
  logic               red_on;
  logic               green_on;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  row_height;
  logic               row_lit;
  logic               col_en;
  logic [ROWS-1:0]    row_onehot;

  assign slot_last  = (slot == SLOT_W'(SCAN_DIV - 1));
  assign row_last   = (row_idx == ROW_W'(ROWS - 1));
  assign frame_wrap = slot_last && row_last;
  assign ack_pulse  = ack_sync[1] && !ack_prev;
  assign lvl_alarm  = (lvl_q >= LVL_ALARM);
  assign red_on     = (lvl_q >= LVL_WARN);
  assign green_on   = !lvl_alarm;

  // Bar height in rows; row 0 is the top, so a row is lit when its height from the bottom is below fill.
  assign fill       = (FILL_W'(lvl_q) * FILL_W'(ROWS)) >> LVL_W;
  assign row_height = FILL_W'(ROWS - 1) - FILL_W'(row_idx);
  assign row_lit    = (row_height < fill);
  assign col_en     = (slot != '0) && row_lit && !dark;
  assign row_onehot = ROWS'(1) << row_idx;

  // Scan position and frame-synchronous level capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot    <= '0;
      row_idx <= '0;
      lvl_q   <= '0;
    end else begin
      slot <= slot_last ? '0 : slot + SLOT_W'(1);
      if (slot_last) begin
        row_idx <= row_last ? '0 : row_idx + ROW_W'(1);
      end
      if (frame_wrap) begin
        lvl_q <= state;
      end
    end
  end

  // Button synchroniser and rising-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync <= '0;
      ack_prev <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[0], btn_ack};
      ack_prev <= ack_sync[1];
    end
  end

  // Alarm FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_st <= S_NORMAL;
      alarm    <= 1'b0;
    end else begin
      alarm_st <= alarm_nxt;
      alarm    <= (alarm_nxt != S_NORMAL);
    end
  end

  // Alarm FSM next state; a level drop takes priority over a simultaneous ack
  always_comb begin
    alarm_nxt = alarm_st;
    case (alarm_st)
      S_NORMAL: if (lvl_alarm) alarm_nxt = S_ALARM;
      S_ALARM: begin
        if (!lvl_alarm)     alarm_nxt = S_NORMAL;
        else if (ack_pulse) alarm_nxt = S_MUTED;
      end
      S_MUTED: begin
        if (!lvl_alarm)     alarm_nxt = S_NORMAL;
        else if (ack_pulse) alarm_nxt = S_ALARM;
      end
      default: alarm_nxt = S_NORMAL;
    endcase
  end

  // Blink phase: held lit in NORMAL so every fresh alarm starts lit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      dark      <= 1'b0;
    end else if (alarm_st == S_NORMAL) begin
      frame_cnt <= '0;
      dark      <= 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt == FRAME_W'(BLINK_FR - 1)) begin
        frame_cnt <= '0;
        dark      <= !dark;
      end else begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  // Beeper square wave, restarted from zero on every entry to ALARM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beep_cnt <= '0;
      beeper   <= 1'b0;
    end else if (alarm_st != S_ALARM) begin
      beep_cnt <= '0;
      beeper   <= 1'b0;
    end else if (beep_cnt == BEEP_W'(BEEP_DIV - 1)) begin
      beep_cnt <= '0;
      beeper   <= !beeper;
    end else begin
      beep_cnt <= beep_cnt + BEEP_W'(1);
    end
  end

  // Registered matrix drive; slot 0 of each row is blanked against ghosting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= ROW_IDLE;
      red_led   <= '0;
      green_led <= '0;
    end else begin
      row       <= ROW_ACT_LOW ? ~row_onehot : row_onehot;
      red_led   <= {COLS{col_en && red_on}};
      green_led <= {COLS{col_en && green_on}};
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan at default parameters: scan walk, bar/colour per level,
// alarm blink, beeper, ack mute toggling and asynchronous reset.
module tb_led_matrix_scan;

  logic       clk;
  logic       rst;
  logic [2:0] state;
  logic       btn_ack;
  logic [7:0] row;
  logic [7:0] red_led;
  logic [7:0] green_led;
  logic       beeper;
  logic       alarm;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  led_matrix_scan dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .btn_ack   (btn_ack),
    .row       (row),
    .red_led   (red_led),
    .green_led (green_led),
    .beeper    (beeper),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick(1);
  endtask

  // Walks one whole frame from a frame boundary; rows >= lit_from are lit
  task automatic check_frame(input int lit_from, input logic r_on, input logic g_on,
                             input logic a_exp);
    logic [7:0] exp_row;
    logic [7:0] cols;
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < 4; s++) begin
        tick(1);
        exp_row = 8'h01 << r;
        exp_row = ~exp_row;
        cols    = (s != 0 && r >= lit_from) ? 8'hFF : 8'h00;
        chk("frame_row", row, exp_row);
        chk("frame_red", red_led, cols & {8{r_on}});
        chk("frame_green", green_led, cols & {8{g_on}});
        if (r == 0 && s == 0) chk("frame_alarm", alarm, a_exp);
      end
    end
  endtask

  initial begin
    logic [7:0] walk;
    rst     = 1'b1;
    state   = 3'd0;
    btn_ack = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_row", row, 8'hFF);
    chk("rst_red", red_led, 8'h00);
    chk("rst_green", green_led, 8'h00);
    chk("rst_beeper", beeper, 1'b0);
    chk("rst_alarm", alarm, 1'b0);

    // Row walk FE..7F, four clocks each, then wrap
    rst = 1'b0;
    cyc = 0;
    tick(1);
    chk("walk_row0", row, 8'hFE);
    chk("walk_red0", red_led, 8'h00);
    for (int r = 1; r <= 8; r++) begin
      tick(4);
      walk = 8'h01 << (r % 8);
      walk = ~walk;
      chk("walk_row", row, walk);
    end

    // Level 3: green rows 5..7
    state = 3'd3;
    tick_to(64);
    check_frame(5, 1'b0, 1'b1, 1'b0);

    // Level change during a frame is not shown until the next frame
    state = 3'd5;
    check_frame(5, 1'b0, 1'b1, 1'b0);
    check_frame(3, 1'b1, 1'b1, 1'b0);

    // Alarm level: red rows 1..7, beeper every 2 clocks
    state = 3'd7;
    tick_to(192);
    check_frame(1, 1'b1, 1'b0, 1'b1);
    chk("alm_alarm", alarm, 1'b1);
    chk("alm_beep224", beeper, 1'b1);
    tick(1);
    chk("alm_beep225", beeper, 1'b0);
    tick(1);
    chk("alm_beep226", beeper, 1'b0);
    tick(1);
    chk("alm_beep227", beeper, 1'b1);

    // Short press mutes
    btn_ack = 1'b1;
    tick(2);
    btn_ack = 1'b0;
    tick_to(231);
    chk("mute_beep231", beeper, 1'b0);
    tick_to(233);
    chk("mute_beep233", beeper, 1'b0);
    chk("mute_alarm", alarm, 1'b1);

    // Long press: one toggle back to beeping
    tick_to(240);
    btn_ack = 1'b1;
    tick_to(245);
    chk("unmute_beep245", beeper, 1'b1);
    tick(1);
    chk("unmute_beep246", beeper, 1'b1);
    tick(1);
    chk("unmute_beep247", beeper, 1'b0);
    tick_to(340);
    btn_ack = 1'b0;
    tick_to(341);
    chk("hold_beep341", beeper, 1'b1);
    tick_to(343);
    chk("hold_beep343", beeper, 1'b0);

    // Mute again, blink continues: 16 lit frames, then dark with rows scanning
    tick_to(350);
    btn_ack = 1'b1;
    tick(2);
    btn_ack = 1'b0;
    tick_to(360);
    chk("mute2_beep", beeper, 1'b0);
    chk("mute2_alarm", alarm, 1'b1);
    tick_to(672);
    check_frame(1, 1'b1, 1'b0, 1'b1);
    check_frame(8, 1'b1, 1'b0, 1'b1);
    chk("dark_beep", beeper, 1'b0);

    // Level drops while muted: alarm clears at the next frame start
    state = 3'd2;
    tick_to(768);
    chk("drop_alarm768", alarm, 1'b1);
    check_frame(6, 1'b0, 1'b1, 1'b0);
    chk("drop_alarm", alarm, 1'b0);
    chk("drop_beep", beeper, 1'b0);

    // Press in NORMAL is ignored; re-entering alarm beeps again, lit phase
    state   = 3'd7;
    btn_ack = 1'b1;
    tick(2);
    btn_ack = 1'b0;
    tick_to(832);
    check_frame(1, 1'b1, 1'b0, 1'b1);
    chk("reent_beep864", beeper, 1'b1);
    tick(1);
    chk("reent_beep865", beeper, 1'b0);

    // Asynchronous reset mid-frame with lit columns and beeper high
    tick_to(871);
    chk("pre_rst_row", row, 8'hFD);
    chk("pre_rst_red", red_led, 8'hFF);
    chk("pre_rst_beep", beeper, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_row", row, 8'hFF);
    chk("arst_red", red_led, 8'h00);
    chk("arst_green", green_led, 8'h00);
    chk("arst_beeper", beeper, 1'b0);
    chk("arst_alarm", alarm, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    tick(1);
    chk("restart_row0", row, 8'hFE);
    tick(4);
    chk("restart_row1", row, 8'hFD);
    tick(1);
    chk("restart_red", red_led, 8'h00);
    chk("restart_alarm", alarm, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
